// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer:
// opcodes, FSM states, command field layout and config defaults.
package mm_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MUL  = 4'h1;
    localparam logic [3:0] OP_LOAD = 4'h2;
    localparam logic [3:0] OP_CFG  = 4'h3;

    localparam int OPC_LSB  = 0;
    localparam int A_LSB    = 4;
    localparam int B_LSB    = 8;
    localparam int C_LSB    = 12;
    localparam int WCFG_LSB = 4;
    localparam int XCFG_LSB = 16;

    // Page field bit 3 picks the W register file when set.
    localparam int FILE_BIT = 3;

    localparam int DEF_W_CFG = 31;
    localparam int DEF_X_CFG = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DRAIN,
        ST_LOAD,
        ST_DONE
    } st_e;

endpackage

// File: rtl/mm_sequencer_if.sv
// Command, load, memory-control and status bundle of the sequencer.
// master = command/stimulus side, slave = sequencer.
interface mm_sequencer_if #(
    parameter int N  = 8,
    parameter int CW = 9,
    parameter int PB = 2
);

    logic          enable;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd;
    logic          in_valid;
    logic [N-1:0]  y_valid_in;

    logic          shift_en;
    logic [CW-1:0] w_idx;
    logic [CW-1:0] x_idx;
    logic          w_last;
    logic          we_w;
    logic          we_x;
    logic [PB-1:0] wr_page;
    logic [PB-1:0] rd_page_w;
    logic [PB-1:0] rd_page_x;
    logic [N-1:0]  y_wr;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output enable, cmd_valid, cmd, in_valid, y_valid_in,
        input  cmd_ready, shift_en, w_idx, x_idx, w_last,
        input  we_w, we_x, wr_page, rd_page_w, rd_page_x,
        input  y_wr, busy, done, err
    );

    modport slave (
        input  enable, cmd_valid, cmd, in_valid, y_valid_in,
        output cmd_ready, shift_en, w_idx, x_idx, w_last,
        output we_w, we_x, wr_page, rd_page_w, rd_page_x,
        output y_wr, busy, done, err
    );

endinterface

// File: rtl/mm_index_counter.sv
// Nested w/x index counter: w wraps at w_cfg, x steps on each w wrap,
// both return to zero after the final (w_cfg, x_cfg) position.
module mm_index_counter #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          clear,
    input  logic [CW-1:0] w_cfg,
    input  logic [CW-1:0] x_cfg,
    output logic [CW-1:0] w_idx,
    output logic [CW-1:0] x_idx,
    output logic          w_last,
    output logic          all_last
);

    logic [CW-1:0] w_q, w_d;
    logic [CW-1:0] x_q, x_d;
    logic          x_last;

    assign w_last   = (w_q == w_cfg);
    assign x_last   = (x_q == x_cfg);
    assign all_last = w_last & x_last;
    assign w_idx    = w_q;
    assign x_idx    = x_q;

    always_comb begin
        w_d = w_q;
        x_d = x_q;
        if (clear) begin
            w_d = '0;
            x_d = '0;
        end else if (step) begin
            if (w_last) begin
                w_d = '0;
                x_d = x_last ? '0 : x_q + CW'(1);
            end else begin
                w_d = w_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= '0;
            x_q <= '0;
        end else begin
            w_q <= w_d;
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/mm_sequencer.sv
// Systolic-array sequencer: decodes commands, steps the w/x shift
// indices for a multiply, drains the array and sequences page loads.
module mm_sequencer #(
    parameter int N   = 8,
    parameter int CW  = 9,
    parameter int PB  = 2,
    parameter int LAT = 2 * N
) (
    input  logic         clk,
    input  logic         reset,
    mm_sequencer_if.slave bus
);

    import mm_pkg::*;

    localparam int LW = CW + $clog2(N) + 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT + 1) : 1;

    st_e           state_q, state_d;
    logic [CW-1:0] w_cfg_q, w_cfg_d;
    logic [CW-1:0] x_cfg_q, x_cfg_d;
    logic [PB-1:0] wr_page_q, wr_page_d;
    logic [PB-1:0] rd_w_q, rd_w_d;
    logic [PB-1:0] rd_x_q, rd_x_d;
    logic          file_w_q, file_w_d;
    logic [LW-1:0] ld_cnt_q, ld_cnt_d;
    logic [DW-1:0] dr_cnt_q, dr_cnt_d;
    logic [N-1:0]  y_wr_q;

    logic [3:0]    opc, fa, fb, fc;
    logic          accept, err_c;
    logic          in_mult, in_load;
    logic          ld_word, ld_last;
    logic [LW-1:0] ld_tgt;

    logic [CW-1:0] c_w_idx, c_x_idx;
    logic          c_w_last, c_all_last;

    logic          unused_cmd;

    assign opc = bus.cmd[OPC_LSB +: 4];
    assign fa  = bus.cmd[A_LSB +: 4];
    assign fb  = bus.cmd[B_LSB +: 4];
    assign fc  = bus.cmd[C_LSB +: 4];

    assign unused_cmd = ^bus.cmd;

    assign accept  = bus.cmd_valid & bus.enable
                   & (state_q == ST_IDLE);
    assign in_mult = (state_q == ST_MULT);
    assign in_load = (state_q == ST_LOAD);
    assign ld_word = in_load & bus.in_valid & bus.enable;

    // W loads cover one row of weights, X loads cover N lanes per row.
    assign ld_tgt  = file_w_q
                   ? LW'(w_cfg_q) + LW'(1)
                   : (LW'(x_cfg_q) + LW'(1)) * LW'(N);
    assign ld_last = (ld_cnt_q == ld_tgt - LW'(1));

    mm_index_counter #(
        .CW(CW)
    ) u_idx (
        .clk      (clk),
        .reset    (reset),
        .step     (in_mult & bus.enable),
        .clear    (~in_mult),
        .w_cfg    (w_cfg_q),
        .x_cfg    (x_cfg_q),
        .w_idx    (c_w_idx),
        .x_idx    (c_x_idx),
        .w_last   (c_w_last),
        .all_last (c_all_last)
    );

    always_comb begin
        state_d   = state_q;
        w_cfg_d   = w_cfg_q;
        x_cfg_d   = x_cfg_q;
        wr_page_d = wr_page_q;
        rd_w_d    = rd_w_q;
        rd_x_d    = rd_x_q;
        file_w_d  = file_w_q;
        ld_cnt_d  = ld_cnt_q;
        dr_cnt_d  = dr_cnt_q;
        err_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (opc)
                        OP_NOP: ;
                        OP_MUL: begin
                            if (!fa[FILE_BIT] && fb[FILE_BIT]
                                && !fc[FILE_BIT]) begin
                                rd_x_d    = PB'(fa);
                                rd_w_d    = PB'(fb);
                                wr_page_d = PB'(fc);
                                state_d   = ST_MULT;
                            end else begin
                                err_c = 1'b1;
                            end
                        end
                        OP_LOAD: begin
                            wr_page_d = PB'(fa);
                            file_w_d  = fa[FILE_BIT];
                            ld_cnt_d  = '0;
                            state_d   = ST_LOAD;
                        end
                        OP_CFG: begin
                            w_cfg_d = bus.cmd[WCFG_LSB +: CW];
                            x_cfg_d = bus.cmd[XCFG_LSB +: CW];
                        end
                        default: err_c = 1'b1;
                    endcase
                end
            end
            ST_MULT: begin
                if (bus.enable && c_all_last) begin
                    dr_cnt_d = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.enable) begin
                    if (dr_cnt_q == DW'(LAT - 1)) begin
                        dr_cnt_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        dr_cnt_d = dr_cnt_q + DW'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (ld_word) begin
                    ld_cnt_d = ld_cnt_q + LW'(1);
                    if (ld_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            w_cfg_q   <= CW'(DEF_W_CFG);
            x_cfg_q   <= CW'(DEF_X_CFG);
            wr_page_q <= '0;
            rd_w_q    <= '0;
            rd_x_q    <= '0;
            file_w_q  <= 1'b0;
            ld_cnt_q  <= '0;
            dr_cnt_q  <= '0;
            y_wr_q    <= '0;
        end else begin
            state_q   <= state_d;
            w_cfg_q   <= w_cfg_d;
            x_cfg_q   <= x_cfg_d;
            wr_page_q <= wr_page_d;
            rd_w_q    <= rd_w_d;
            rd_x_q    <= rd_x_d;
            file_w_q  <= file_w_d;
            ld_cnt_q  <= ld_cnt_d;
            dr_cnt_q  <= dr_cnt_d;
            if (bus.enable) y_wr_q <= bus.y_valid_in;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE) & bus.enable;
    assign bus.err       = err_c;
    assign bus.shift_en  = in_mult & bus.enable;
    assign bus.we_w      = ld_word & file_w_q;
    assign bus.we_x      = ld_word & ~file_w_q;
    assign bus.w_idx     = in_load ? ld_cnt_q[CW-1:0] : c_w_idx;
    assign bus.x_idx     = c_x_idx;
    assign bus.w_last    = c_w_last;
    assign bus.wr_page   = wr_page_q;
    assign bus.rd_page_w = rd_w_q;
    assign bus.rd_page_x = rd_x_q;
    assign bus.y_wr      = y_wr_q;

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer: multiply, drain, load, config,
// error decode, enable stalls and mid-operation reset.
module tb_mm_sequencer;

    localparam int N  = 8;
    localparam int CW = 9;
    localparam int PB = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    int shifts, wlasts, done_cyc, wew, wex, ymis, gapbad;
    int xseq;

    always #5 clk = ~clk;

    mm_sequencer_if #(.N(N), .CW(CW), .PB(PB)) bus ();

    mm_sequencer #(.N(N), .CW(CW), .PB(PB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] c);
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
    endtask

    // One command; check err in the accept cycle and idle afterwards.
    task automatic one_cmd(input string tag, input logic [31:0] c,
                           input bit exp_err);
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        #1;
        chk({tag, "_err"}, bus.err, exp_err);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        #1;
        chk({tag, "_err_off"}, bus.err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic run(input logic [31:0] c, input int gap_at,
                       input int gap_len, input bit ld,
                       input int max);
        logic [N-1:0]  yexp;
        logic [CW-1:0] wfz;
        shifts = 0; wlasts = 0; done_cyc = -1;
        wew = 0; wex = 0; ymis = 0; gapbad = 0; xseq = 0;
        yexp = '0;
        wfz = '0;
        issue(c);
        for (int k = 1; k <= max && done_cyc < 0; k++) begin
            bus.enable = !(k >= gap_at && k < gap_at + gap_len);
            bus.in_valid = ld && (k % 3 != 0);
            bus.y_valid_in = N'(k * 29 + 3);
            #1;
            if (bus.y_wr !== yexp) ymis++;
            if (bus.shift_en) begin
                shifts++;
                if (bus.w_last) wlasts++;
                if (bus.w_idx == 0)
                    xseq = (xseq << 4) | int'(bus.x_idx);
            end
            if (bus.we_w) wew++;
            if (bus.we_x) wex++;
            if (!bus.enable) begin
                if (k == gap_at) wfz = bus.w_idx;
                else if (bus.w_idx != wfz) gapbad++;
                if (bus.shift_en || bus.done) gapbad++;
            end
            if (bus.done) done_cyc = k;
            if (bus.enable) yexp = bus.y_valid_in;
            @(posedge clk); #1;
        end
        bus.enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.y_valid_in = '0;
        #1;
        chk("post_done", bus.done, 0);
        chk("post_busy", bus.busy, 0);
    endtask

    initial begin
        int dn;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
        bus.in_valid = 1'b0;
        bus.y_valid_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_shift", bus.shift_en, 0);
        chk("rst_widx", bus.w_idx, 0);
        chk("rst_xidx", bus.x_idx, 0);
        chk("rst_page", bus.wr_page, 0);
        chk("rst_ywr", bus.y_wr, 0);
        chk("rst_done", bus.done, 0);

        // default config: 32 x 2 shifts, drain 16, done at 81
        run(32'h00C0801, 0, 0, 1'b0, 300);
        chk("def_shifts", shifts, 64);
        chk("def_wlast", wlasts, 2);
        chk("def_done", done_cyc, 81);
        chk("def_ywr", ymis, 0);

        // 5-cycle stall mid-multiply
        run(32'h00C0801, 20, 5, 1'b0, 300);
        chk("gap_shifts", shifts, 64);
        chk("gap_frozen", gapbad, 0);
        chk("gap_done", done_cyc, 86);
        chk("gap_ywr", ymis, 0);

        // load W file page 1, 32 words with gaps
        run(32'h00000092, 0, 0, 1'b1, 300);
        chk("ld_wew", wew, 32);
        chk("ld_wex", wex, 0);
        chk("ld_done", done_cyc, 48);
        chk("ld_page", bus.wr_page, 1);
        chk("ld_shift", shifts, 0);

        one_cmd("badmul", 32'h00000001, 1'b1);
        one_cmd("badmul_a", 32'h00000891, 1'b1);
        one_cmd("op7", 32'h00000007, 1'b1);
        one_cmd("nop", 32'h00000000, 1'b0);

        // config w_cfg=7 x_cfg=3, multiply X1 W2(0xA) Y2
        issue(32'h00030073);
        run(32'h00002A11, 0, 0, 1'b0, 300);
        chk("cfg_shifts", shifts, 32);
        chk("cfg_xseq", xseq, 32'h123);
        chk("cfg_wlast", wlasts, 4);
        chk("cfg_done", done_cyc, 49);
        chk("cfg_ywr", ymis, 0);
        chk("cfg_rdx", bus.rd_page_x, 1);
        chk("cfg_rdw", bus.rd_page_w, 2);
        chk("cfg_wrp", bus.wr_page, 2);

        // abort at w_idx=10 under w_cfg=15
        issue(32'h000100F3);
        issue(32'h00C0801);
        for (int i = 0; i < 100 && bus.w_idx != 10; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_widx", bus.w_idx, 10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_widx0", bus.w_idx, 0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dn++;
            @(posedge clk); #1;
        end
        chk("abort_nodone", dn, 0);

        // w_cfg must be back at 31: default run timing again
        run(32'h00C0801, 0, 0, 1'b0, 300);
        chk("post_rst_shifts", shifts, 64);
        chk("post_rst_done", done_cyc, 81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
